// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD converter
// Optional leading-zero blanking (4'hF) on the DONE load when BIN2BCD_LEADING_BLANK_EN is defined.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                ovf
);

  localparam int ACC_W = 4*DIGITS + 4;
  localparam int OUT_W = 4*DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(BIN_W - 1);
  localparam logic [63:0]      C_LIMIT = 64'(10**DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t r_state;
  state_t w_next;
  logic   w_load;
  logic   w_shift;
  logic   w_finish;

  logic [BIN_W-1:0] r_sr;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_big;
  logic             r_busy;
  logic             r_done;
  logic [OUT_W-1:0] r_bcd;
  logic             r_ovf;

  logic [ACC_W-1:0] w_acc_adj;
  logic [63:0]      w_bin_ext;
  logic             w_ovf;
  logic [OUT_W-1:0] w_bcd_plain;
  logic [OUT_W-1:0] w_bcd_shaped;
  logic [OUT_W-1:0] w_bcd_final;

  assign w_bin_ext = {{(64-BIN_W){1'b0}}, bin_in};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == C_LAST) w_next = S_DONE;
      end
      S_DONE: begin
        w_finish = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Add-3 correction on every digit, including the extra overflow digit.
  always_comb begin
    w_acc_adj = r_acc;
    for (int d = 0; d < DIGITS + 1; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
  end

  assign w_ovf       = r_big | (r_acc[ACC_W-1 -: 4] != 4'd0);
  assign w_bcd_plain = r_acc[OUT_W-1:0];

`ifdef BIN2BCD_LEADING_BLANK_EN
  // Blank zeros from the MSD down until the first non-zero digit; LSD always shown.
  always_comb begin
    logic w_lead;
    w_bcd_shaped = w_bcd_plain;
    w_lead       = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (w_lead && (w_bcd_plain[4*d +: 4] == 4'd0)) w_bcd_shaped[4*d +: 4] = 4'hF;
      else                                             w_lead = 1'b0;
    end
  end
`else
  assign w_bcd_shaped = w_bcd_plain;
`endif

  assign w_bcd_final = w_ovf ? {DIGITS{4'h9}} : w_bcd_shaped;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_big  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_sr   <= bin_in;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_big  <= (w_bin_ext >= C_LIMIT);
        r_busy <= 1'b1;
      end
      if (w_shift) begin
        r_acc <= {w_acc_adj[ACC_W-2:0], r_sr[BIN_W-1]};
        r_sr  <= r_sr << 1;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_finish) begin
        r_bcd  <= w_bcd_final;
        r_ovf  <= w_ovf;
        r_busy <= 1'b0;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign bcd_out = r_bcd;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed and random checks of bin2bcd_seq against an arithmetic model
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    int x;
`ifdef BIN2BCD_LEADING_BLANK_EN
    bit lead;
`endif
    if (v > 9999) return 16'h9999;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BIN2BCD_LEADING_BLANK_EN
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is positioned at a negedge; start is driven immediately so back-to-back works.
  task automatic run_conv(input int v, input string tag);
    int n;
    bit seen;
    start  = 1'b1;
    bin_in = 14'(v);
    @(posedge clk);
    #1 start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      bin_in = 14'($urandom);
      if (done) seen = 1'b1;
      else begin
        check({tag, ":busy"}, {31'd0, busy}, 32'd1);
        n++;
      end
    end
    check({tag, ":latency"}, n, 32'd15);
    check({tag, ":bcd"}, {16'd0, bcd_out}, {16'd0, model_bcd(v)});
    check({tag, ":ovf"}, {31'd0, ovf}, {31'd0, (v > 9999)});
    check({tag, ":busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int dones;
    bit seen;
    int v;

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst:busy", {31'd0, busy}, 32'd0);
    check("rst:done", {31'd0, done}, 32'd0);
    check("rst:bcd",  {16'd0, bcd_out}, 32'd0);
    check("rst:ovf",  {31'd0, ovf}, 32'd0);

    run_conv(1234, "c1234");
    run_conv(0, "c0");
    run_conv(9999, "c9999");
    run_conv(10000, "c10000");
    run_conv(16383, "c16383");
    run_conv(42, "c42");
    run_conv(0, "c0b");

    // Start pulse while busy must be dropped, not queued.
    start  = 1'b1;
    bin_in = 14'd57;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (c == 5) begin
        start  = 1'b1;
        bin_in = 14'd88;
      end else begin
        start = 1'b0;
      end
    end
    check("drop:dones", dones, 32'd1);
    check("drop:bcd", {16'd0, bcd_out}, {16'd0, model_bcd(57)});
    check("drop:busy", {31'd0, busy}, 32'd0);

    // Reset mid-conversion aborts without a done pulse.
    start  = 1'b1;
    bin_in = 14'd1234;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort:busy", {31'd0, busy}, 32'd0);
    check("abort:bcd",  {16'd0, bcd_out}, 32'd0);
    check("abort:ovf",  {31'd0, ovf}, 32'd0);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort:no_done", {31'd0, seen}, 32'd0);
    run_conv(321, "c321");

    for (int k = 0; k < 16; k++) begin
      v = (k % 4 == 0) ? int'($urandom_range(9990, 16383)) : int'($urandom_range(0, 16383));
      run_conv(v, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential double-dabble converter that turns the adder's binary result into packed BCD digits for the FND display controller.
- Sits directly upstream of fnd_controller; its bcd_out feeds that block's bcd input.
- Runs a start/busy/done handshake so the adder path can launch a conversion and know when the digits are stable.
- Holds the last result steady between conversions so the display never flickers on partial values.

Parameters:
- BIN_W, 14, width of the binary input; the conversion takes BIN_W shift cycles.
- DIGITS, 4, number of BCD digits produced; bcd_out is 4*DIGITS bits wide.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request a conversion of bin_in; honoured only in IDLE.
- bin_in  input  BIN_W  unsigned binary value; sampled on the edge where start is accepted.
- busy  output  1  high while a conversion is in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse; bcd_out and ovf are valid from this cycle on.
- bcd_out  output  4*DIGITS  packed BCD, most significant digit in the top nibble.
- ovf  output  1  high when the last converted value exceeded 10^DIGITS-1.

Behaviour:
- Reset (synchronous, active-high, one clk edge): state=IDLE, busy=0, done=0, bcd_out=0, ovf=0, shift register and counter cleared.
- Reset asserted during a conversion aborts it: no done pulse is produced and bcd_out is cleared.
- States:
  - IDLE: on start=1, latch bin_in into the shift register, clear the BCD accumulator, set counter=0, then go to SHIFT.
  - SHIFT: each cycle, every accumulator digit >=5 gets +3, then {accumulator, shift register} shifts left by 1 and counter increments. After the BIN_W-th shift, go to DONE.
  - DONE: load bcd_out and ovf from the accumulator, assert done for this single cycle, then return to IDLE.
- Latency: start accepted at edge T; done=1 and bcd_out valid during the cycle after edge T+BIN_W+1 (15 cycles for BIN_W=14).
- busy=1 in SHIFT and DONE and falls when IDLE is re-entered.
- A new start may be accepted the cycle after done.
- start while busy=1 is ignored and not queued; bin_in changes while busy have no effect.
- Accumulator width: 4*DIGITS+4 bits, so the extra digit is available for overflow detection.
- Overflow rule: if the extra digit is non-zero or bin_in >= 10^DIGITS, then bcd_out = all digits 9 (16'h9999 at defaults) and ovf=1. Otherwise ovf=0.
- bcd_out and ovf hold their value until the next DONE or reset.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: BIN2BCD_LEADING_BLANK_EN.
- Defined: on the DONE load, leading zero digits, scanning down from the MSD, are replaced by 4'hF (blank code for fnd_controller). The least significant digit is never blanked. Example: 42 gives 16'hFF42, 0 gives 16'hFFF0.
- Not defined: plain BCD with leading zeros (42 gives 16'h0042). ovf saturation output is unaffected either way.

Test Plan:
- Reset 1 cycle, then start with bin_in=1234 → done exactly 15 cycles after the start edge, bcd_out=16'h1234, ovf=0, busy high throughout.
- bin_in=0, then bin_in=9999 back-to-back (second start the cycle after done) → 16'h0000 then 16'h9999, both with ovf=0.
- bin_in=10000, then 16383 → bcd_out=16'h9999 and ovf=1 for both.
- Convert 57; pulse start with bin_in=88 at cycle 5 of the conversion → only one done, bcd_out=16'h0057, and the second start is dropped.
- Start 1234; assert reset at cycle 7 → no done pulse, bcd_out=0, busy=0 next cycle. A fresh start with 321 then gives 16'h0321.
- With BIN2BCD_LEADING_BLANK_EN defined: 42 gives 16'hFF42 and 0 gives 16'hFFF0; without the macro, 42 gives 16'h0042.
